fifo_drain: RTL and testbench
=============================

// Module: fifo_drain
// PURPOSE
//  Consumer-side controller for the 8-deep synchronous FIFO (fifo_top / fifo_ns / fifo_out family).
//  Issues rd_en to the FIFO, captures dout one cycle later on rd_ack, and re-presents words on a
//  valid/ready output stream through a 2-entry skid buffer. Sustains one word/cycle when m_ready=1.
//  Sits between the FIFO read port and any downstream consumer.
// PARAMETERS
//  DATA_WIDTH  32  width of fifo_dout / m_data
//  CNT_WIDTH   4   width of FIFO data_count (depth 8 -> 0..8)
//  WCNT_WIDTH  16  width of delivered-word counter
// PORTS
//  clk          in   1           rising-edge clock (single clock domain)
//  reset_n      in   1           asynchronous, active-low reset
//  en           in   1           1 = drain FIFO; 0 = stop issuing reads
//  data_count   in   CNT_WIDTH   FIFO occupancy, registered, updates cycle after rd_en
//  fifo_dout    in   DATA_WIDTH  FIFO read data, valid in cycle after rd_en
//  rd_ack       in   1           FIFO read acknowledge (cycle after rd_en)
//  rd_err       in   1           FIFO read error / underflow (cycle after rd_en)
//  rd_en        out  1           FIFO read request
//  m_valid      out  1           output word valid
//  m_data       out  DATA_WIDTH  output word
//  m_ready      in   1           downstream accepts m_data when m_valid & m_ready
//  state        out  2           FSM state (debug)
//  word_cnt     out  WCNT_WIDTH  words delivered on output, wraps modulo 2^WCNT_WIDTH
//  err_cnt      out  8           rd_err count, saturates at 8'hFF
// BEHAVIOUR
//  Reset (reset_n=0, async): rd_en=0, m_valid=0, m_data=0, state=IDLE, word_cnt=0, err_cnt=0,
//   buffer occupancy=0, in-flight flag=0. Deassertion mid-transfer discards buffered/in-flight words.
//  Read issue (registered rd_en): asserted next cycle iff en=1 AND occ+inflight(next)<2 AND
//   avail>0, where avail = data_count - (rd_en currently 1 ? 1 : 0). Never underflows when
//   data_count=1 (no back-to-back rd_en until data_count reflects the first read).
//  Capture: cycle after rd_en, rd_ack=1 -> fifo_dout written to skid tail; rd_err=1 -> nothing
//   written, err_cnt+1 (saturating). Neither -> treated as rd_err. in-flight cleared either way.
//  Output: m_valid = (occ!=0); m_data = head entry, held stable while m_valid & !m_ready.
//   Pop on m_valid & m_ready; word_cnt+1 per pop. Capture and pop same cycle -> occ unchanged,
//   strict FIFO order preserved. m_data returns to 0 when occ=0.
//  Latency: rd_en -> m_valid = 2 cycles (rd_en, capture, visible) with empty skid buffer.
//  FSM (state encoding):
//   IDLE  2'b00: en=0, occ=0, no in-flight. -> RUN when en=1.
//   RUN   2'b01: en=1, occ+inflight<2. -> FULL when occ+inflight=2; -> DRAIN when en falls & occ/inflight>0;
//                -> IDLE when en falls & nothing pending.
//   FULL  2'b10: occ+inflight=2, no rd_en. -> RUN when a pop frees a slot & en=1; -> DRAIN if en=0.
//   DRAIN 2'b11: en=0, words pending; in-flight still captured, buffer still delivered, no rd_en.
//                -> IDLE when occ=0 & no in-flight; -> RUN if en re-asserts.
//  en deasserted: rd_en drops next cycle; outstanding read still completes and is delivered.
//  data_count>8 (illegal): treated as 8.
// TESTING
//  1 Reset: reset_n=0 async mid-cycle -> all outputs 0, state=2'b00 immediately.
//  2 Stream: data_count=8, words A0..A7, en=1, m_ready=1 -> 8 rd_en pulses, m_data A0..A7 in order,
//    one per cycle after 2-cycle latency, word_cnt=8, rd_en never high when data_count=0.
//  3 Underflow guard: data_count=1, en=1 -> exactly one rd_en pulse, no rd_err, word_cnt=1.
//  4 Backpressure: data_count=8, m_ready=0 -> 2 words buffered, state=FULL, m_data stable;
//    m_ready=1 -> remaining 6 words delivered in order, none lost or duplicated.
//  5 Error: force rd_err=1 on 3 reads -> err_cnt=3, those slots not captured, m_valid stays 0 for them.
//  6 Stop: en=0 in cycle after rd_en -> in-flight word delivered, state DRAIN -> IDLE, rd_en stays 0.

Source files
------------

// File: rtl/fifo_drain.sv
// Read-side controller for the 8-deep synchronous FIFO: issues rd_en, captures dout on rd_ack,
// and re-presents words on a valid/ready stream through a 2-entry skid buffer.
module fifo_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4,
  parameter int WCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [CNT_WIDTH-1:0]  data_count,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  rd_ack,
  input  logic                  rd_err,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            state,
  output logic [WCNT_WIDTH-1:0] word_cnt,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FULL  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t                cur_st, nxt_st;
  logic [1:0]            occ, occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] ent0, ent1;
  logic                  wr, pop, rd_en_nxt;
  logic [CNT_WIDTH-1:0]  dc_eff;
  logic [2:0]            pend_nxt;

  always_comb begin
    dc_eff    = (data_count > CNT_WIDTH'(8)) ? CNT_WIDTH'(8) : data_count;
    wr        = inflight & rd_ack & ~rd_err;
    pop       = (occ != 2'd0) & m_ready;
    occ_nxt   = occ + {1'b0, wr} - {1'b0, pop};
    pend_nxt  = {1'b0, occ_nxt} + {2'b00, rd_en};
    // rd_en still high means data_count has not yet seen that read; discount it.
    rd_en_nxt = en && (pend_nxt < 3'd2) && (dc_eff > CNT_WIDTH'(rd_en));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_st <= IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // State is a function of the pending work after this edge, so every arc
  // (including FULL->RUN on a pop and DRAIN->RUN on en) falls out directly.
  always_comb begin
    nxt_st = cur_st;
    if (!en) begin
      nxt_st = (pend_nxt == 3'd0) ? IDLE : DRAIN;
    end else begin
      nxt_st = (pend_nxt >= 3'd2) ? FULL : RUN;
    end
  end

  always_comb begin
    state   = cur_st;
    m_valid = (occ != 2'd0);
    m_data  = m_valid ? ent0 : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en    <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      ent0     <= '0;
      ent1     <= '0;
      word_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      rd_en    <= rd_en_nxt;
      inflight <= rd_en;
      occ      <= occ_nxt;
      if (pop) begin
        word_cnt <= word_cnt + WCNT_WIDTH'(1);
      end
      if (inflight && !wr && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      case ({wr, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= fifo_dout;
          else             ent1 <= fifo_dout;
        end
        2'b01: begin
          ent0 <= ent1;
          ent1 <= '0;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= fifo_dout;
          end else begin
            ent0 <= ent1;
            ent1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: behavioural FIFO model plus a word-order scoreboard,
// a table of drain scenarios and hand-written corner sequences.
module tb_fifo_drain;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int WW = 16;

  logic          clk, reset_n, en, rd_ack, rd_err, rd_en, m_valid, m_ready;
  logic [CW-1:0] data_count;
  logic [DW-1:0] fifo_dout, m_data;
  logic [1:0]    state;
  logic [WW-1:0] word_cnt;
  logic [7:0]    err_cnt;

  fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .WCNT_WIDTH(WW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .data_count(data_count),
    .fifo_dout(fifo_dout), .rd_ack(rd_ack), .rd_err(rd_err), .rd_en(rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .state(state),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int  inj_left   = 0;
  int  inj_pct    = 0;
  int  underflows = 0;
  int  exp_err    = 0;
  int  pops       = 0;
  int  rd_pulses  = 0;
  bit  model_on   = 0;
  bit  mon_on     = 0;

  // FIFO read port: a read requested in one cycle is answered in the next.
  initial begin
    logic r;
    forever begin
      @(negedge clk);
      r = rd_en;
      @(posedge clk);
      #1;
      rd_ack    = 1'b0;
      rd_err    = 1'b0;
      fifo_dout = $urandom;
      if (model_on && r) begin
        if (inj_left > 0 || (inj_pct > 0 && $urandom_range(99) < inj_pct)) begin
          rd_err = 1'b1;
          if (inj_left > 0) inj_left--;
          exp_err++;
        end else if (fq.size() == 0) begin
          rd_err = 1'b1;
          underflows++;
          exp_err++;
        end else begin
          fifo_dout = fq.pop_front();
          rd_ack    = 1'b1;
          exp_q.push_back(fifo_dout);
        end
      end
      data_count = (fq.size() > 15) ? 4'd15 : CW'(fq.size());
    end
  end

  // Output monitor: order, hold under backpressure, zero data when idle.
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      rd_pulses += int'(rd_en);
      if (!mon_on) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) check("hold", {31'b0, m_valid, m_data}, {31'b0, 1'b1, prev_data});
        if (!m_valid) check("idle_data", 64'(m_data), 64'd0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) check("extra_word", 64'd1, 64'd0);
          else check("order", 64'(m_data), 64'(exp_q.pop_front()));
          pops++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back($urandom);
  endtask

  task automatic run_until_drained(input int pct, input int budget);
    int quiet = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      m_ready = ($urandom_range(99) < pct);
      if (fq.size() == 0 && exp_q.size() == 0 && inj_left == 0 && !rd_en &&
          !rd_ack && !rd_err && !m_valid) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    check("drain_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    int n_words;
    int n_inj;
    int ready_pct;
    int exp_words;
    int exp_errs;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   w0, r0, e_tot, lat, found;

    vecs[0] = '{8, 0, 100, 8, 0};
    vecs[1] = '{1, 0, 100, 1, 0};
    vecs[2] = '{5, 0,  50, 5, 0};
    vecs[3] = '{8, 3, 100, 8, 3};
    vecs[4] = '{3, 0,  30, 3, 3};
    vecs[5] = '{8, 2,  70, 8, 5};

    reset_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    fifo_dout = '0; rd_ack = 1'b0; rd_err = 1'b0; data_count = '0;

    #12;
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    tick(); tick();
    reset_n = 1'b1; model_on = 1; mon_on = 1;
    tick();
    check("init_state", 64'(state), 64'd0);
    check("init_outs", {rd_en, m_valid, m_data, word_cnt, err_cnt}, 64'd0);

    // Latency from an empty skid buffer, then full-rate stream of 8.
    w0 = pops; r0 = rd_pulses;
    push_words(8); en = 1'b1; m_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (rd_en) found = 1;
    end
    check("first_rd_en", 64'(found), 64'd1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (m_valid) break;
    end
    check("latency", 64'(lat), 64'd2);
    run_until_drained(100, 200);
    check("stream_words", 64'(word_cnt), 64'(w0 + 8));
    check("stream_rd_pulses", 64'(rd_pulses - r0), 64'd8);
    en = 1'b0; tick(); tick();
    check("stream_idle", 64'(state), 64'd0);

    // Asynchronous reset mid-transfer discards everything buffered.
    push_words(8); en = 1'b1; m_ready = 1'b1;
    repeat (5) tick();
    m_ready = 1'b0;
    repeat (4) tick();
    mon_on = 0; model_on = 0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_outs", {rd_en, m_valid, m_data, word_cnt, err_cnt}, 64'd0);
    check("async_rst_state", 64'(state), 64'd0);
    fq.delete(); exp_q.delete(); pops = 0; exp_err = 0; en = 1'b0;
    tick(); tick();
    reset_n = 1'b1; model_on = 1; mon_on = 1;
    tick();

    // Table of drain scenarios: words, injected errors, downstream readiness.
    for (int v = 0; v < 6; v++) begin
      w0 = pops;
      push_words(vecs[v].n_words);
      inj_left = vecs[v].n_inj;
      en = 1'b1;
      run_until_drained(vecs[v].ready_pct, 600);
      check($sformatf("vec%0d_words", v), 64'(word_cnt), 64'(WW'(w0 + vecs[v].exp_words)));
      check($sformatf("vec%0d_errs", v), 64'(err_cnt), 64'(vecs[v].exp_errs));
      en = 1'b0; tick(); tick();
      check($sformatf("vec%0d_idle", v), 64'(state), 64'd0);
    end
    check("no_underflow_table", 64'(underflows), 64'd0);

    // Backpressure: two words fill the skid buffer, then reads stop.
    w0 = pops; r0 = rd_pulses;
    push_words(8); m_ready = 1'b0; en = 1'b1;
    repeat (8) tick();
    check("bp_state_full", 64'(state), 64'd2);
    check("bp_m_valid", 64'(m_valid), 64'd1);
    check("bp_rd_pulses", 64'(rd_pulses - r0), 64'd2);
    run_until_drained(100, 200);
    check("bp_words", 64'(word_cnt), 64'(w0 + 8));
    en = 1'b0; tick(); tick();

    // Stop right after the first read: the in-flight word still comes out.
    w0 = pops;
    push_words(8); m_ready = 1'b1; en = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (rd_en) found = 1;
    end
    check("stop_rd_seen", 64'(found), 64'd1);
    #1;
    en = 1'b0;
    r0 = rd_pulses;
    @(negedge clk);
    check("stop_drain_state", 64'(state), 64'd3);
    check("stop_rd_low", 64'(rd_en), 64'd0);
    repeat (10) @(negedge clk);
    check("stop_no_reads", 64'(rd_pulses), 64'(r0));
    check("stop_idle", 64'(state), 64'd0);
    check("stop_words", 64'(word_cnt), 64'(w0 + 1));
    tick();
    fq.delete();
    tick();

    // Random traffic against the scoreboard.
    inj_pct = 10;
    for (int c = 0; c < 600; c++) begin
      tick();
      if ($urandom_range(99) < 5) en = ~en;
      m_ready = ($urandom_range(99) < 60);
      if (fq.size() < 8 && $urandom_range(99) < 40) push_words(1);
    end
    en = 1'b1; inj_pct = 0;
    run_until_drained(100, 500);
    check("rand_word_cnt", 64'(word_cnt), 64'(WW'(pops)));
    check("rand_err_cnt", 64'(err_cnt), 64'((exp_err > 255) ? 255 : exp_err));
    check("rand_no_underflow", 64'(underflows), 64'd0);

    // Error counter saturation.
    push_words(1); inj_left = 300; en = 1'b1;
    run_until_drained(100, 1500);
    check("err_saturate", 64'(err_cnt), 64'hFF);
    en = 1'b0; tick(); tick();
    check("final_idle", 64'(state), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
